// File: rtl/sdram_init_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_init_seq_pkg
//  Description : Shared SDRAM definitions: command encodings on
//                {cs_n, ras_n, cas_n, we_n}, init FSM state codes, the
//                default mode-register word and a small sizing helper.
//                The rd/wr controller imports the same definitions.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package sdram_init_seq_pkg;

  // Command encodings {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_INH = 4'b1111;

  // Init FSM state codes
  localparam int         STATE_W  = 3;
  localparam logic [2:0] ST_WAIT  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_PRE_W = 3'd2;
  localparam logic [2:0] ST_REF   = 3'd3;
  localparam logic [2:0] ST_REF_W = 3'd4;
  localparam logic [2:0] ST_MRS   = 3'd5;
  localparam logic [2:0] ST_MRS_W = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // CAS latency 3, sequential burst, burst length 4
  localparam logic [12:0] DEFAULT_MODE_REG = 13'h032;

  // PRECHARGE ALL uses addr[10]=1, all other bits 0
  localparam logic [12:0] C_ADDR_PRE_ALL = 13'h0400;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : sdram_init_seq_pkg
`default_nettype wire

// File: rtl/sdram_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_init_seq
//  Description : SDRAM power-up initialisation sequencer (133 MHz domain).
//                After reset release: T_WAIT NOP cycles with CKE high,
//                PRECHARGE ALL, REF_COUNT x AUTO REFRESH, LOAD MODE
//                REGISTER, then init_done (sticky until reset). Every
//                reset replays the whole sequence from a full T_WAIT.
//  Ports       : clk_133     in   SDRAM clock
//                rst_n       in   synchronous active-low reset
//                sdram_cke   out  clock enable
//                sdram_cs_n  out  chip select
//                sdram_ras_n out  row strobe
//                sdram_cas_n out  column strobe
//                sdram_we_n  out  write enable
//                sdram_ba    out  bank address [1:0]
//                sdram_addr  out  address / mode word [12:0]
//                init_done   out  sequence complete
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_init_seq
  import sdram_init_seq_pkg::*;
#(
  parameter int          T_WAIT    = 26600,
  parameter int          T_RP      = 3,
  parameter int          T_RFC     = 9,
  parameter int          REF_COUNT = 8,
  parameter int          T_MRD     = 2,
  parameter logic [12:0] MODE_REG  = DEFAULT_MODE_REG
) (
  input  logic        clk_133,
  input  logic        rst_n,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic        init_done
);

  localparam int CNT_MAX = max2(max2(T_WAIT, T_RP), max2(T_RFC, T_MRD));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REF_W   = $clog2(REF_COUNT + 1);

  // The delay counter holds the number of cycles spent in the current
  // state, counting the current one. It is 1 on entry to every state and
  // 0 under reset, so the first post-reset WAIT cycle brings it to 1.
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_WAIT_END = CNT_W'(T_WAIT);
  localparam logic [CNT_W-1:0] C_RP_END   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] C_RFC_END  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] C_MRD_END  = CNT_W'(T_MRD - 1);
  localparam logic [REF_W-1:0] C_REF_ONE  = REF_W'(1);
  localparam logic [REF_W-1:0] C_REF_LAST = REF_W'(REF_COUNT);

  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [REF_W-1:0]   r_ref;

  logic [STATE_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [REF_W-1:0]   w_ref_nxt;

  logic               w_cke;
  logic [3:0]         w_cmd;
  logic [1:0]         w_ba;
  logic [12:0]        w_addr;
  logic               w_done;

  // --------------------------------------------------------------------
  // State, counters and output registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk_133) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT;
      r_cnt       <= '0;
      r_ref       <= '0;
      sdram_cke   <= 1'b0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_INH;
      sdram_ba    <= 2'b00;
      sdram_addr  <= 13'h0000;
      init_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ref       <= w_ref_nxt;
      sdram_cke   <= w_cke;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= w_cmd;
      sdram_ba    <= w_ba;
      sdram_addr  <= w_addr;
      init_done   <= w_done;
    end
  end

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  // After each refresh (REF when T_RFC=1, otherwise the end of REF_W) the
  // refresh count picks another REF or moves on to MRS. The count is
  // bumped on entry to REF, so it already includes the refresh just issued.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + C_CNT_ONE;
    w_ref_nxt   = r_ref;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt == C_WAIT_END) begin
          w_state_nxt = ST_PRE;
          w_cnt_nxt   = C_CNT_ONE;
        end
      end
      ST_PRE: begin
        w_cnt_nxt = C_CNT_ONE;
        if (T_RP > 1) begin
          w_state_nxt = ST_PRE_W;
        end else begin
          w_state_nxt = ST_REF;
          w_ref_nxt   = r_ref + C_REF_ONE;
        end
      end
      ST_PRE_W: begin
        if (r_cnt == C_RP_END) begin
          w_state_nxt = ST_REF;
          w_cnt_nxt   = C_CNT_ONE;
          w_ref_nxt   = r_ref + C_REF_ONE;
        end
      end
      ST_REF, ST_REF_W: begin
        if ((r_state == ST_REF) && (T_RFC > 1)) begin
          w_state_nxt = ST_REF_W;
          w_cnt_nxt   = C_CNT_ONE;
        end else if ((r_state == ST_REF) || (r_cnt == C_RFC_END)) begin
          w_cnt_nxt = C_CNT_ONE;
          if (r_ref == C_REF_LAST) begin
            w_state_nxt = ST_MRS;
          end else begin
            w_state_nxt = ST_REF;
            w_ref_nxt   = r_ref + C_REF_ONE;
          end
        end
      end
      ST_MRS: begin
        if (T_MRD > 1) begin
          w_state_nxt = ST_MRS_W;
          w_cnt_nxt   = C_CNT_ONE;
        end else begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end
      end
      ST_MRS_W: begin
        if (r_cnt == C_MRD_END) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end
      end
      ST_DONE: begin
        // Parked: the counter is held so it can never wrap.
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
        w_ref_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------
  // Decoded from the next state so the registered pins line up with the
  // state entered on the same edge: a command appears exactly on its edge.
  always_comb begin
    w_cke  = 1'b1;
    w_cmd  = CMD_NOP;
    w_ba   = 2'b00;
    w_addr = 13'h0000;
    w_done = 1'b0;
    case (w_state_nxt)
      ST_PRE: begin
        w_cmd  = CMD_PRE;
        w_addr = C_ADDR_PRE_ALL;
      end
      ST_REF: begin
        w_cmd = CMD_REF;
      end
      ST_MRS: begin
        w_cmd  = CMD_MRS;
        w_addr = MODE_REG;
      end
      ST_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_cmd = CMD_NOP;
      end
    endcase
  end

endmodule : sdram_init_seq
`default_nettype wire

// File: tb/tb_sdram_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_init_seq
//  Description : Self-checking bench for sdram_init_seq. A reduced-timing
//                instance covers reset, sequence timing, post-done idle and
//                reset pulses; a default-parameter instance covers the full
//                200 us power-up timing. Expected pin states come from a
//                closed-form timeline per edge index.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_init_seq;

  localparam int          TW_S    = 10;
  localparam int          RC_S    = 2;
  localparam int          TW_D    = 26600;
  localparam int          RC_D    = 8;
  localparam int          T_RP    = 3;
  localparam int          T_RFC   = 9;
  localparam int          T_MRD   = 2;
  localparam logic [12:0] MODE    = 13'h032;

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        done;
  } obs_t;

  logic        clk_133 = 1'b0;
  logic        rst_n   = 1'b0;
  logic        rst_n_d = 1'b0;

  logic        cke_s, cs_s, ras_s, cas_s, we_s, done_s;
  logic [1:0]  ba_s;
  logic [12:0] addr_s;
  logic        cke_d, cs_d, ras_d, cas_d, we_d, done_d;
  logic [1:0]  ba_d;
  logic [12:0] addr_d;

  obs_t obs_s, obs_d;
  assign obs_s = {cke_s, cs_s, ras_s, cas_s, we_s, ba_s, addr_s, done_s};
  assign obs_d = {cke_d, cs_d, ras_d, cas_d, we_d, ba_d, addr_d, done_d};

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];

  always #5 clk_133 = ~clk_133;

  sdram_init_seq #(
    .T_WAIT(TW_S), .T_RP(T_RP), .T_RFC(T_RFC),
    .REF_COUNT(RC_S), .T_MRD(T_MRD), .MODE_REG(MODE)
  ) u_dut_s (
    .clk_133(clk_133), .rst_n(rst_n),
    .sdram_cke(cke_s), .sdram_cs_n(cs_s), .sdram_ras_n(ras_s),
    .sdram_cas_n(cas_s), .sdram_we_n(we_s), .sdram_ba(ba_s),
    .sdram_addr(addr_s), .init_done(done_s)
  );

  sdram_init_seq u_dut_d (
    .clk_133(clk_133), .rst_n(rst_n_d),
    .sdram_cke(cke_d), .sdram_cs_n(cs_d), .sdram_ras_n(ras_d),
    .sdram_cas_n(cas_d), .sdram_we_n(we_d), .sdram_ba(ba_d),
    .sdram_addr(addr_d), .init_done(done_d)
  );

  function automatic obs_t inh_state();
    obs_t o;
    o = '{cke: 1'b0, cmd: 4'b1111, ba: 2'b00, addr: 13'h0, done: 1'b0};
    return o;
  endfunction

  // Expected pins at post-reset edge e.
  function automatic obs_t model(input int e, input int tw, input int rc);
    obs_t o;
    int   t_ref0;
    int   t_mrs;
    o = '{cke: 1'b1, cmd: 4'b0111, ba: 2'b00, addr: 13'h0, done: 1'b0};
    t_ref0 = tw + T_RP;
    t_mrs  = t_ref0 + rc * T_RFC;
    if (e == tw) begin
      o.cmd  = 4'b0010;
      o.addr = 13'h0400;
    end
    for (int k = 0; k < rc; k++)
      if (e == t_ref0 + k * T_RFC) o.cmd = 4'b0001;
    if (e == t_mrs) begin
      o.cmd  = 4'b0000;
      o.addr = MODE;
    end
    if (e >= t_mrs + T_MRD) o.done = 1'b1;
    return o;
  endfunction

  // Called just after a sampled edge: holds reset for n edges, then
  // releases so the following edge is post-reset edge 0.
  task automatic hold_reset(input bit sel, input int n, input string name);
    if (sel) rst_n_d = 1'b0; else rst_n = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(inh_state());
    for (int i = 0; i < n; i++) begin
      obs_t ex, act;
      @(posedge clk_133); #1;
      ex  = exp_q.pop_front();
      act = sel ? obs_d : obs_s;
      total++;
      if (act !== ex) begin
        bad++;
        $display("FAIL %s rst_cycle=%0d actual=%h required=%h", name, i, act, ex);
      end
    end
    if (sel) rst_n_d = 1'b1; else rst_n = 1'b1;
  endtask

  task automatic check_cycles(input bit sel, input int start_e, input int n,
                              input int tw, input int rc, input string name);
    for (int i = 0; i < n; i++) exp_q.push_back(model(start_e + i, tw, rc));
    for (int i = 0; i < n; i++) begin
      obs_t ex, act;
      @(posedge clk_133); #1;
      ex  = exp_q.pop_front();
      act = sel ? obs_d : obs_s;
      total++;
      if (act !== ex) begin
        bad++;
        $display("FAIL %s edge=%0d actual=%h required=%h", name, start_e + i, act, ex);
      end
    end
  endtask

  task automatic test_reset();
    hold_reset(1'b0, 5, "reset_hold");
    check_cycles(1'b0, 0, TW_S, TW_S, RC_S, "wait_nop");
  endtask

  task automatic test_sequence();
    check_cycles(1'b0, TW_S, 40 - TW_S, TW_S, RC_S, "sequence");
  endtask

  task automatic test_after_done();
    check_cycles(1'b0, 40, 1000, TW_S, RC_S, "idle_after_done");
  endtask

  task automatic test_reset_after_done();
    hold_reset(1'b0, 1, "reset_after_done");
    check_cycles(1'b0, 0, 40, TW_S, RC_S, "replay_after_done");
  endtask

  task automatic test_mid_reset();
    hold_reset(1'b0, 1, "pre_mid_reset");
    check_cycles(1'b0, 0, 18, TW_S, RC_S, "before_mid_reset");
    hold_reset(1'b0, 1, "mid_reset");
    check_cycles(1'b0, 0, 40, TW_S, RC_S, "replay_after_mid_reset");
  endtask

  task automatic test_defaults();
    hold_reset(1'b1, 2, "default_reset");
    check_cycles(1'b1, 0, 26700, TW_D, RC_D, "default_sequence");
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_after_done();
    test_reset_after_done();
    test_mid_reset();
    test_defaults();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sdram_init_seq
`default_nettype wire
